// File: rtl/regfile_pkg.sv
// Shared constants for the regfile input controller:
// FSM state codes, touchscreen field selects, register count.
package regfile_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COMMIT = 2'd1;
  localparam logic [1:0] S_CLEAR  = 2'd2;

  localparam logic [1:0] SEL_RADDR1 = 2'd0;
  localparam logic [1:0] SEL_RADDR2 = 2'd1;
  localparam logic [1:0] SEL_WADDR  = 2'd2;
  localparam logic [1:0] SEL_WDATA  = 2'd3;

  localparam int NUM_REGS = 32;

endpackage

// File: rtl/regfile_input_ctrl_sw_sync_edge.sv
// Switch synchroniser (STAGES flops) plus rising-edge pulse.
// Ports: clk, resetn (sync, active-low), i_sw async in, o_rise pulse.
module sw_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_sw,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_sw};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/regfile_input_ctrl.sv
// Regfile input controller: touchscreen operand staging, switch-driven
// single commits and 32-entry clear sweep onto the regfile write port.
module regfile_input_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              input_valid,
  input  logic [DATA_W-1:0] input_value,
  input  logic [1:0]        input_sel,
  input  logic              wen_sw,
  input  logic              clr_sw,
  output logic [ADDR_W-1:0] raddr1,
  output logic [ADDR_W-1:0] raddr2,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic w_w_rise;
  logic w_c_rise;

  logic [1:0]        r_state;
  logic              r_pend_w;
  logic              r_pend_c;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [ADDR_W-1:0] r_raddr1;
  logic [ADDR_W-1:0] r_raddr2;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_busy;
  logic [CNT_W-1:0]  r_wr_count;

  sw_sync_edge #(.STAGES(SYNC_STAGES)) u_wen (
    .clk    (clk),
    .resetn (resetn),
    .i_sw   (wen_sw),
    .o_rise (w_w_rise)
  );

  sw_sync_edge #(.STAGES(SYNC_STAGES)) u_clr (
    .clk    (clk),
    .resetn (resetn),
    .i_sw   (clr_sw),
    .o_rise (w_c_rise)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_pend_w   <= 1'b0;
      r_pend_c   <= 1'b0;
      r_clr_idx  <= '0;
      r_raddr1   <= '0;
      r_raddr2   <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_busy     <= 1'b0;
      r_wr_count <= '0;
    end else begin
      if (input_valid) begin
        unique case (input_sel)
          SEL_RADDR1: r_raddr1 <= input_value[ADDR_W-1:0];
          SEL_RADDR2: r_raddr2 <= input_value[ADDR_W-1:0];
          SEL_WADDR:  r_waddr  <= input_value[ADDR_W-1:0];
          default:    r_wdata  <= input_value;
        endcase
      end

      // Requests stick until serviced; a rise in the launch
      // cycle is a fresh request and stays pending.
      r_pend_w <= r_pend_w | w_w_rise;
      r_pend_c <= r_pend_c | w_c_rise;

      unique case (r_state)
        S_COMMIT: begin
          r_state <= S_IDLE;
          r_rf_we <= 1'b0;
          r_busy  <= 1'b0;
          if (r_wr_count != '1)
            r_wr_count <= r_wr_count + 1'b1;
        end
        S_CLEAR: begin
          if (r_clr_idx == LAST_IDX) begin
            r_state <= S_IDLE;
            r_rf_we <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_clr_idx  <= r_clr_idx + 1'b1;
            r_rf_waddr <= r_clr_idx + 1'b1;
          end
        end
        default: begin
          r_rf_we <= 1'b0;
          r_busy  <= 1'b0;
          if (r_pend_c) begin
            r_state    <= S_CLEAR;
            r_pend_c   <= w_c_rise;
            r_clr_idx  <= '0;
            r_rf_we    <= 1'b1;
            r_busy     <= 1'b1;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
          end else if (r_pend_w) begin
            r_state    <= S_COMMIT;
            r_pend_w   <= w_w_rise;
            r_rf_we    <= 1'b1;
            r_busy     <= 1'b1;
            r_rf_waddr <= r_waddr;
            r_rf_wdata <= r_wdata;
          end
        end
      endcase
    end
  end

  assign raddr1   = r_raddr1;
  assign raddr2   = r_raddr2;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign busy     = r_busy;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_regfile_input_ctrl.sv
// Scoreboard bench for regfile_input_ctrl: expected write-port
// transactions are queued by stimulus and popped by a monitor.
module tb_regfile_input_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  // Narrow counter so saturation is reachable in a short run.
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          input_valid;
  logic [DW-1:0] input_value;
  logic [1:0]    input_sel;
  logic          wen_sw;
  logic          clr_sw;
  logic [AW-1:0] raddr1, raddr2, waddr, rf_waddr;
  logic [DW-1:0] wdata, rf_wdata;
  logic          rf_we, busy;
  logic [CW-1:0] wr_count;

  regfile_input_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .input_valid(input_valid), .input_value(input_value),
    .input_sel(input_sel), .wen_sw(wen_sw), .clr_sw(clr_sw),
    .raddr1(raddr1), .raddr2(raddr2), .waddr(waddr), .wdata(wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .wr_count(wr_count)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                  nm, act, exp, cyc);
  endtask

  // Monitor: every write-port pulse must match the queue head.
  always @(negedge clk) begin
    chk("busy_vs_we", {63'd0, busy}, {63'd0, rf_we});
    if (rf_we === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_write", 64'(rf_waddr), 64'hFFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rf_waddr", 64'(rf_waddr), 64'(e.a));
        chk("rf_wdata", 64'(rf_wdata), 64'(e.d));
        if (e.cyc >= 0) chk("we_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic put(input logic [1:0] s, input logic [DW-1:0] v);
    @(negedge clk);
    input_valid = 1'b1;
    input_sel   = s;
    input_value = v;
    @(negedge clk);
    input_valid = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int c);
    exp_t e;
    e.a = a; e.d = d; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic push_clear(input int c0, input int n);
    for (int i = 0; i < n; i++) push(AW'(i), '0, c0 + i);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  int m;

  initial begin
    resetn = 1'b0; input_valid = 1'b0; input_value = '0;
    input_sel = '0; wen_sw = 1'b0; clr_sw = 1'b0;
    wait_n(3);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_count", 64'(wr_count), 64'd0);
    resetn = 1'b1;
    wait_n(2);

    // Staging
    put(2'd2, 32'h0000_0025);
    chk("stage_waddr", 64'(waddr), 64'd5);
    put(2'd3, 32'hDEAD_BEEF);
    chk("stage_wdata", 64'(wdata), 64'hDEADBEEF);
    chk("stage_raddr1", 64'(raddr1), 64'd0);
    chk("stage_raddr2", 64'(raddr2), 64'd0);

    // Single commit with latency: first sampled at edge m+1.
    @(negedge clk);
    m = cyc;
    push(5'd5, 32'hDEAD_BEEF, m + 4);
    wen_sw = 1'b1;
    wait_n(100);
    chk("commit_count", 64'(wr_count), 64'd1);
    chk("commit_drained", 64'(q.size()), 64'd0);
    wen_sw = 1'b0;
    wait_n(5);

    // Clear sweep, with a raddr1 capture in the middle.
    @(negedge clk);
    m = cyc;
    push_clear(m + 4, 32);
    clr_sw = 1'b1;
    wait_n(15);
    put(2'd0, 32'd7);
    wait_n(25);
    chk("clr_raddr1", 64'(raddr1), 64'd7);
    chk("clr_count", 64'(wr_count), 64'd1);
    chk("clr_drained", 64'(q.size()), 64'd0);
    clr_sw = 1'b0;
    wait_n(5);

    // Simultaneous: clear first, then one commit after an IDLE cycle.
    put(2'd2, 32'd9);
    @(negedge clk);
    m = cyc;
    push_clear(m + 4, 32);
    push(5'd9, 32'hDEAD_BEEF, m + 37);
    wen_sw = 1'b1;
    clr_sw = 1'b1;
    wait_n(50);
    chk("both_count", 64'(wr_count), 64'd2);
    chk("both_drained", 64'(q.size()), 64'd0);
    wen_sw = 1'b0;
    clr_sw = 1'b0;
    wait_n(5);

    // Reset while the sweep sits at index 10.
    @(negedge clk);
    m = cyc;
    push_clear(m + 4, 11);
    clr_sw = 1'b1;
    wait_n(14);
    resetn = 1'b0;
    clr_sw = 1'b0;
    @(negedge clk);
    chk("mid_rst_we", 64'(rf_we), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_raddr1", 64'(raddr1), 64'd0);
    chk("mid_rst_waddr", 64'(waddr), 64'd0);
    chk("mid_rst_wdata", 64'(wdata), 64'd0);
    chk("mid_rst_count", 64'(wr_count), 64'd0);
    wait_n(1);
    resetn = 1'b1;
    wait_n(50);
    chk("mid_rst_drained", 64'(q.size()), 64'd0);

    // Saturation: 6 commits reach max-1, 3 more stick at max.
    put(2'd2, 32'd3);
    put(2'd3, 32'h1234_5678);
    for (int k = 0; k < 9; k++) begin
      push(5'd3, 32'h1234_5678, -1);
      wen_sw = 1'b1;
      wait_n(6);
      wen_sw = 1'b0;
      wait_n(4);
      if (k == 5) chk("sat_pre", 64'(wr_count), 64'd6);
    end
    chk("sat_count", 64'(wr_count), 64'd7);
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
